// File: rtl/fetch_unit_pkg.sv
// Shared fetch definitions: instruction width, PC step, reset PC default,
// decode field positions and the prefetch queue entry type.
package fetch_unit_pkg;

  localparam int          INSTR_W      = 16;
  localparam logic [31:0] PC_STEP      = 32'd2;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // Field positions in the instruction word, shared with decode.
  localparam int FMT_MSB  = 15;
  localparam int FMT_LSB  = 14;
  localparam int INST_MSB = 13;
  localparam int INST_LSB = 10;
  localparam int REG0_MSB = 9;
  localparam int REG0_LSB = 5;
  localparam int REG1_MSB = 4;
  localparam int REG1_LSB = 0;

  typedef struct packed {
    logic [INSTR_W-1:0] ir;
    logic [31:0]        pc;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Prefetch queue: synchronous FIFO with flush. The extra pointer bit tells
// full from empty, so the occupancy is simply the pointer difference.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  fetch_entry_t             i_data,
  input  logic                     i_pop,
  output fetch_entry_t             o_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (i_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (i_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries data only and is deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) mem_q[wr_ptr_q[AW-1:0]] <= i_data;
  end

  assign o_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign o_count = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential halfword fetch over a req/ack port into
// a prefetch queue, with taken-branch redirect flushing all wrong-path work.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  output logic               o_mem_req,
  output logic [31:0]        o_mem_addr,
  input  logic               i_mem_ack,
  input  logic [INSTR_W-1:0] i_mem_data,
  input  logic               i_redir,
  input  logic [31:0]        i_redir_pc,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_ir,
  output logic [31:0]        o_pc,
  input  logic               i_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count;
  logic          push, pop;
  fetch_entry_t  push_entry, head;

  assign o_mem_req  = (count < CW'(DEPTH));
  assign o_mem_addr = fetch_pc_q;
  assign o_valid    = (count != '0);

  // A redirect discards the coincident ack and wins over any pop.
  assign push = o_mem_req && i_mem_ack && !i_redir;
  assign pop  = o_valid && i_ready && !i_redir;

  assign push_entry = '{ir: i_mem_data, pc: fetch_pc_q};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (i_redir)   fetch_pc_d = align_pc(i_redir_pc);
    else if (push) fetch_pc_d = fetch_pc_q + PC_STEP;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) fetch_pc_q <= RESET_PC;
    else       fetch_pc_q <= fetch_pc_d;
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_redir),
    .i_push  (push),
    .i_data  (push_entry),
    .i_pop   (pop),
    .o_data  (head),
    .o_count (count)
  );

  // Mask the head when empty so outputs read zero out of reset.
  assign o_ir = o_valid ? head.ir : '0;
  assign o_pc = o_valid ? head.pc : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed throughput/backpressure/redirect
// vectors, asynchronous reset, and randomized traffic against a queue model.
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_req2;
  logic [31:0] mem_addr, mem_addr2;
  logic        ack;
  logic [15:0] mem_data, mem_data2;
  logic        redir;
  logic [31:0] redir_pc;
  logic        valid, valid2;
  logic [15:0] ir, ir2;
  logic [31:0] pc, pc2;
  logic        ready;

  int checks = 0;
  int errors = 0;

  // Reference model state: fetch address and queue of fetched pcs.
  logic [31:0] m_fetch;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    h = a * 32'h9E37_79B1;
    return h[31:16] ^ a[15:0];
  endfunction

  assign mem_data  = mem_word(mem_addr);
  assign mem_data2 = mem_word(mem_addr2);

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .i_clk(clk), .i_rst(rst),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr),
    .i_mem_ack(ack), .i_mem_data(mem_data),
    .i_redir(redir), .i_redir_pc(redir_pc),
    .o_valid(valid), .o_ir(ir), .o_pc(pc), .i_ready(ready)
  );

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) dut2 (
    .i_clk(clk), .i_rst(rst),
    .o_mem_req(mem_req2), .o_mem_addr(mem_addr2),
    .i_mem_ack(1'b1), .i_mem_data(mem_data2),
    .i_redir(1'b0), .i_redir_pc(32'h0),
    .o_valid(valid2), .o_ir(ir2), .o_pc(pc2), .i_ready(1'b1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_fetch = 32'h0;
  endtask

  // Inputs are set before the call; check now, then advance one clock.
  task automatic model_cycle();
    logic m_req;
    #1;
    m_req = (q.size() < DEPTH);
    chk("m_req", {31'b0, mem_req}, {31'b0, m_req});
    chk("m_addr", mem_addr, m_fetch);
    chk("m_valid", {31'b0, valid}, {31'b0, q.size() != 0});
    if (q.size() != 0) begin
      chk("m_pc", pc, q[0]);
      chk("m_ir", {16'b0, ir}, {16'b0, mem_word(q[0])});
    end
    @(posedge clk);
    if (redir) begin
      q.delete();
      m_fetch = {redir_pc[31:1], 1'b0};
    end else begin
      if (q.size() != 0 && ready) void'(q.pop_front());
      if (m_req && ack) begin
        q.push_back(m_fetch);
        m_fetch = m_fetch + 32'd2;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic        ack;
    logic        rdy;
    logic        rd;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[19];

  initial begin
    int wait_cnt;
    rst = 1'b1; ack = 1'b0; ready = 1'b0; redir = 1'b0; redir_pc = '0;

    // Backpressure fill/drain, then redirect with queue of 3 and coincident ack.
    vecs[0]  = '{1, 0, 0, 32'h0,   1, 32'h0,   0, 32'h0};
    vecs[1]  = '{1, 0, 0, 32'h0,   1, 32'h2,   1, 32'h0};
    vecs[2]  = '{1, 0, 0, 32'h0,   1, 32'h4,   1, 32'h0};
    vecs[3]  = '{1, 0, 0, 32'h0,   1, 32'h6,   1, 32'h0};
    vecs[4]  = '{1, 0, 0, 32'h0,   0, 32'h8,   1, 32'h0};
    vecs[5]  = '{1, 1, 0, 32'h0,   0, 32'h8,   1, 32'h0};
    vecs[6]  = '{1, 1, 0, 32'h0,   1, 32'h8,   1, 32'h2};
    vecs[7]  = '{0, 1, 0, 32'h0,   1, 32'hA,   1, 32'h4};
    vecs[8]  = '{0, 1, 0, 32'h0,   1, 32'hA,   1, 32'h6};
    vecs[9]  = '{0, 1, 0, 32'h0,   1, 32'hA,   1, 32'h8};
    vecs[10] = '{0, 0, 0, 32'h0,   1, 32'hA,   0, 32'h0};
    vecs[11] = '{1, 0, 0, 32'h0,   1, 32'hA,   0, 32'h0};
    vecs[12] = '{1, 0, 0, 32'h0,   1, 32'hC,   1, 32'hA};
    vecs[13] = '{1, 0, 0, 32'h0,   1, 32'hE,   1, 32'hA};
    vecs[14] = '{1, 0, 1, 32'h101, 1, 32'h10,  1, 32'hA};
    vecs[15] = '{0, 1, 0, 32'h0,   1, 32'h100, 0, 32'h0};
    vecs[16] = '{1, 1, 0, 32'h0,   1, 32'h100, 0, 32'h0};
    vecs[17] = '{0, 1, 0, 32'h0,   1, 32'h102, 1, 32'h100};
    vecs[18] = '{0, 1, 0, 32'h0,   1, 32'h102, 0, 32'h0};

    // Reset values.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", {31'b0, mem_req}, 32'd1);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_ir", {16'b0, ir}, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_addr2", mem_addr2, 32'hFFFF_FFFC);
    @(negedge clk);

    // Sustained throughput, plus wrap-around on the second instance.
    rst = 1'b0; ack = 1'b1; ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("tp_addr", mem_addr, 32'(2 * k));
      chk("tp_valid", {31'b0, valid}, {31'b0, k >= 1});
      if (k >= 1) begin
        chk("tp_pc", pc, 32'(2 * (k - 1)));
        chk("tp_ir", {16'b0, ir}, {16'b0, mem_word(32'(2 * (k - 1)))});
      end
      if (k >= 1 && k <= 4) begin
        chk("wrap_valid", {31'b0, valid2}, 32'd1);
        chk("wrap_pc", pc2, 32'hFFFF_FFFC + 32'(2 * (k - 1)));
      end
      @(posedge clk);
      @(negedge clk);
    end

    // Directed vectors.
    do_reset();
    for (int i = 0; i < 19; i++) begin
      ack = vecs[i].ack; ready = vecs[i].rdy;
      redir = vecs[i].rd; redir_pc = vecs[i].rpc;
      #1;
      chk($sformatf("vec%0d_req", i), {31'b0, mem_req}, {31'b0, vecs[i].e_req});
      chk($sformatf("vec%0d_addr", i), mem_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d_valid", i), {31'b0, valid}, {31'b0, vecs[i].e_valid});
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d_pc", i), pc, vecs[i].e_pc);
        chk($sformatf("vec%0d_ir", i), {16'b0, ir}, {16'b0, mem_word(vecs[i].e_pc)});
      end
      @(posedge clk);
      @(negedge clk);
    end
    redir = 1'b0;

    // Asynchronous reset mid-stream with ack held high.
    do_reset();
    ack = 1'b1; ready = 1'b1;
    repeat (6) model_cycle();
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, valid}, 32'd0);
    chk("arst_addr", mem_addr, 32'h0);
    chk("arst_req", {31'b0, mem_req}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    model_cycle();
    #1;
    chk("arst_first_valid", {31'b0, valid}, 32'd1);
    chk("arst_first_pc", pc, 32'h0);
    repeat (4) model_cycle();

    // Randomized waits, backpressure and redirects against the model.
    wait_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      ack = (wait_cnt == 0);
      ready = ($urandom_range(0, 2) != 0);
      redir = ($urandom_range(0, 39) == 0);
      redir_pc = redir ? $urandom : 32'h0;
      if (ack && q.size() < DEPTH) wait_cnt = $urandom_range(0, 5);
      else if (wait_cnt > 0) wait_cnt--;
      model_cycle();
    end
    redir = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the processor's decode/execute logic. It generates sequential halfword program addresses, fetches 16-bit instruction words over a request/acknowledge memory port, and buffers them in a small prefetch queue. Decode consumes each instruction and its PC through a valid/ready handshake. Taken branches redirect the fetch address and flush all buffered and in-flight wrong-path work.

## Interface
- DEPTH, 4, prefetch queue entries (power of two, ≥2)
- RESET_PC, 32'h0000_0000, first fetch address after reset (bit 0 must be 0)
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  asynchronous, active-high reset
- o_mem_req  out  1  fetch request valid
- o_mem_addr  out  32  halfword address of requested instruction
- i_mem_ack  in  1  memory accepts request; i_mem_data valid this cycle
- i_mem_data  in  16  instruction word returned with ack
- i_redir  in  1  taken-branch redirect, single-cycle pulse
- i_redir_pc  in  32  redirect target; bit 0 ignored (treated as 0)
- o_valid  out  1  o_ir/o_pc hold a valid instruction
- o_ir  out  16  instruction word, fmt in [15:14], inst [13:10], reg0 [9:5], reg1 [4:0]
- o_pc  out  32  address the instruction was fetched from
- i_ready  in  1  decode accepts the offered instruction

## Operation
- State: fetch_pc (32b), queue of DEPTH entries {ir, pc}, occupancy count 0..DEPTH.
- o_mem_req = (count < DEPTH); o_mem_addr = fetch_pc. Both depend only on registered state.
- Memory transaction completes in any cycle with o_mem_req && i_mem_ack. Request may be dropped before ack; unacked requests are abandoned.
- Accepted ack, no redirect: push {i_mem_data, fetch_pc}; fetch_pc += 2, modulo 2^32 (0xFFFF_FFFE wraps to 0).
- Pop on o_valid && i_ready; o_valid = (count != 0); o_ir/o_pc show queue head.
- Push and pop in same cycle: count unchanged. Ack never arrives when full, because request is gated by count < DEPTH.
- Redirect (highest priority): next cycle count = 0, fetch_pc = {i_redir_pc[31:1],1'b0}. Any ack in the redirect cycle is discarded and does not advance fetch_pc. Pop handshake in the redirect cycle still counts as a transfer; decode squashes it.
- i_ir/o_pc are don't-care when o_valid = 0 and must not be checked.

## Timing
- Reset values: o_mem_req = 1, o_mem_addr = RESET_PC, o_valid = 0, o_ir = 0, o_pc = 0, count = 0.
- Reset asserted mid-transaction clears all state immediately; a concurrent ack is ignored.
- Fetch latency: ack in cycle N, then o_valid with that word in cycle N+1 (if queue was empty).
- Redirect latency: i_redir in cycle R, then o_mem_addr = target in R+1. With zero-wait memory (ack in R+1), the first target instruction has o_valid in R+2.
- Sustained throughput with ack tied high and i_ready high: one instruction per cycle.
- Backpressure: i_ready low holds the head stable. Fetching continues until count = DEPTH, then o_mem_req drops. It rises again the cycle after the first pop.

## Structure
- The shared defines header holds INSTR_W = 16, PC_STEP = 2, and the RESET_PC default. It also holds the fmt/inst field positions already used by decode.
- Sub-module fetch_fifo: synchronous FIFO with DEPTH parameter, push/pop, synchronous flush, and count output. Pointers use log2(DEPTH)+1 bits to distinguish full from empty.
- fetch_unit holds fetch_pc, request gating, and redirect/flush priority.

## Test plan
- Reset, ack tied high, i_ready high: o_mem_addr sequence 0,2,4,6… and o_pc matches o_ir one cycle later. Expect one instruction per cycle and no gaps.
- i_ready low, ack high: after 4 acks o_mem_req = 0 and count = 4. Head pc 0 is held. Raising i_ready drains 0,2,4,6 and request resumes next cycle at addr 8.
- Redirect to 0x0000_0101 while queue holds 3 entries and an ack coincides: acked word dropped, o_valid = 0 next cycle, next o_mem_addr = 0x100. The first output pc is 0x100.
- Random ack waits (0–5 cycles) and random i_ready: output pc stream strictly +2. Every o_ir equals a memory model word at o_pc, with no duplicates or losses.
- RESET_PC = 0xFFFF_FFFC: o_pc sequence FFFF_FFFC, FFFF_FFFE, 0000_0000, 0000_0002.
- Assert i_rst mid-stream with ack high: o_valid = 0 and o_mem_addr = RESET_PC immediately (asynchronously). The first instruction after release is from RESET_PC.
